// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    // Arbiter FSM: IDLE hunts for a requester, LOCK forwards the owner's packet.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ     = 2;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_GAP_TIMEOUT = 255;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
//
// Handshake: a byte moves on a given channel in exactly the cycle where its
// valid and ready are both high at the rising clock edge. A source may raise,
// drop or change valid/data at any time (held values are not assumed). Ready
// may depend combinationally on valid; valid never depends on ready.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          timeout;

    // Requesters plus the UART transmitter, seen from outside the arbiter.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, timeout
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of 'valid'
// found scanning upward from index 'ptr' with wrap-around, as a one-hot vector.
// Kept generic so other arbiters can reuse it.
module uart_tx_arbiter_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic                 any
);
    logic found;

    // Scan priority order ptr, ptr+1, ... and keep only the first hit.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && (j == (int'(ptr) + k) % N) && valid[j]) begin
                    onehot[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Ownership is held for a whole packet (until a byte with last=1 is taken)
// so messages never interleave; the next owner is chosen round-robin.
// An owner that goes silent mid-packet loses the lock after GAP_TIMEOUT idle
// cycles; cycles stalled by the transmitter never count as idle.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus,
    output arb_state_t         state_dbg
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic                  pick_any;
    logic [PW-1:0]         pick_idx;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic [PW-1:0]         owner_inc;
    logic                  xfer;

    uart_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid  (bus.req_valid),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    // Binary index of the picked requester, stored so the owner mux is cheap.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    // Select the current owner's valid, last flag and byte.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PW'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_inc = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
    assign xfer      = (state_q == ST_LOCK) && own_valid && bus.tx_ready;

    // Zero-latency forwarding while locked; everything quiet while idle.
    always_comb begin
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        if (state_q == ST_LOCK) begin
            bus.tx_valid  = own_valid;
            bus.tx_data   = own_data;
            bus.req_ready = grant_q & {NUM_REQ{bus.tx_ready}};
        end
    end

    assign bus.grant   = grant_q;
    assign bus.timeout = timeout_q;
    assign state_dbg   = state_q;

    // Next-state logic: grant in IDLE, release on last byte or idle timeout.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOCK;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    gap_d   = '0;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    // A transfer always clears the gap, so it beats a timeout.
                    gap_d = '0;
                    if (own_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = owner_inc;
                    end
                end else if (!own_valid) begin
                    if (gap_q + GW'(1) == GW'(GAP_TIMEOUT)) begin
                        state_d   = ST_IDLE;
                        grant_d   = '0;
                        ptr_d     = owner_inc;
                        gap_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                // valid && !tx_ready: UART backpressure, gap left untouched.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner, pointer, gap counter and timeout pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
